// File: rtl/phys_reg_file_mp.sv
// -----------------------------------------------------------------------------
// phys_reg_file_mp
//
// Parametrised multi-port physical register file sitting between the commit
// stage (writer) and the issue/operand-fetch stages (readers).
//
// After reset a clear sequencer walks every entry and writes zero. While it
// runs, all commits are dropped and every enabled read port loads zero.
// `ready` rises exactly DEPTH rising edges after reset is released.
//
// Write ports: a port's write takes effect only when commitAllow and its
// commitVec bit are high, its address is below DEPTH, and it does not target
// p0 while ZERO_REG is set. When several ports hit the same entry, the
// highest-indexed port wins.
//
// Read ports are registered (1-cycle latency) and gated by `en`. Each port
// resolves its value in this order:
//   1. zero for an out-of-range address, or for p0 when ZERO_REG is set;
//   2. the same-cycle write data when BYPASS is set (highest-indexed port);
//   3. the stored entry.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   en           : read-port enable (readData holds when low)
//   commitAllow  : global write enable
//   commitVec    : per-port write valid, bit k = port k
//   readSelect   : N_READ addresses, port i at [i*ADDR_W +: ADDR_W]
//   writeSelect  : N_WRITE addresses, port k at [k*ADDR_W +: ADDR_W]
//   writeData    : N_WRITE data words, port k at [k*DATA_W +: DATA_W]
//   readData     : N_READ registered data words, port i at [i*DATA_W +: DATA_W]
//   ready        : high once the clear sequence has completed
// -----------------------------------------------------------------------------
module phys_reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6,
    parameter int N_READ   = 12,
    parameter int N_WRITE  = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       commitAllow,
    input  logic [N_WRITE-1:0]         commitVec,
    input  logic [N_READ*ADDR_W-1:0]   readSelect,
    input  logic [N_WRITE*ADDR_W-1:0]  writeSelect,
    input  logic [N_WRITE*DATA_W-1:0]  writeData,
    output logic [N_READ*DATA_W-1:0]   readData,
    output logic                       ready
);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t                     state_r;
    state_t                     stateNext_s;
    logic [ADDR_W-1:0]          clrPtr_r;
    logic [ADDR_W-1:0]          clrPtrNext_s;
    logic                       readyNext_s;
    logic [N_WRITE-1:0]         wrEn_s;
    logic [N_READ*DATA_W-1:0]   readVal_s;
    logic [DATA_W-1:0]          pr_r [DEPTH];

    // True when the address names an existing entry.
    function automatic logic addrInRange(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_EXT);
    endfunction

    // True when the address is the hard-wired zero register.
    function automatic logic addrIsZero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 32'sd0) && (a == {ADDR_W{1'b0}});
    endfunction

    // State, clear pointer and ready flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= CLEAR;
            clrPtr_r <= {ADDR_W{1'b0}};
            ready    <= 1'b0;
        end else begin
            state_r  <= stateNext_s;
            clrPtr_r <= clrPtrNext_s;
            ready    <= readyNext_s;
        end
    end

    // Clear sequencer next-state: leave CLEAR on the edge that clears the last entry.
    always_comb begin
        stateNext_s  = state_r;
        clrPtrNext_s = clrPtr_r;
        readyNext_s  = ready;
        case (state_r)
            CLEAR: begin
                if (clrPtr_r == LAST_ADDR) begin
                    stateNext_s  = RUN;
                    clrPtrNext_s = {ADDR_W{1'b0}};
                    readyNext_s  = 1'b1;
                end else begin
                    stateNext_s  = CLEAR;
                    clrPtrNext_s = clrPtr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    readyNext_s  = 1'b0;
                end
            end
            RUN: begin
                stateNext_s  = RUN;
                clrPtrNext_s = clrPtr_r;
                readyNext_s  = 1'b1;
            end
            default: begin
                stateNext_s  = CLEAR;
                clrPtrNext_s = {ADDR_W{1'b0}};
                readyNext_s  = 1'b0;
            end
        endcase
    end

    // Effective write enables; commits are only honoured in RUN.
    always_comb begin
        wrEn_s = {N_WRITE{1'b0}};
        for (int k = 0; k < N_WRITE; k++) begin
            wrEn_s[k] = (state_r == RUN) && commitAllow && commitVec[k]
                        && addrInRange(writeSelect[k*ADDR_W +: ADDR_W])
                        && !addrIsZero(writeSelect[k*ADDR_W +: ADDR_W]);
        end
    end

    // Array update. Ports are applied in ascending order, so on a shared
    // address the last (highest-indexed) non-blocking write is the one kept.
    always_ff @(posedge clk) begin
        if (state_r == CLEAR) begin
            pr_r[clrPtr_r] <= {DATA_W{1'b0}};
        end else begin
            for (int k = 0; k < N_WRITE; k++) begin
                if (wrEn_s[k]) begin
                    pr_r[writeSelect[k*ADDR_W +: ADDR_W]] <= writeData[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Per-port read value: zero/out-of-range first, then bypass, then stored data.
    always_comb begin
        readVal_s = {(N_READ*DATA_W){1'b0}};
        for (int i = 0; i < N_READ; i++) begin
            if (!addrInRange(readSelect[i*ADDR_W +: ADDR_W])
                || addrIsZero(readSelect[i*ADDR_W +: ADDR_W])) begin
                readVal_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else begin
                readVal_s[i*DATA_W +: DATA_W] = pr_r[readSelect[i*ADDR_W +: ADDR_W]];
                if (BYPASS != 32'sd0) begin
                    // Ascending scan: a later match overrides, giving the highest port.
                    for (int k = 0; k < N_WRITE; k++) begin
                        if (wrEn_s[k] && (writeSelect[k*ADDR_W +: ADDR_W]
                                          == readSelect[i*ADDR_W +: ADDR_W])) begin
                            readVal_s[i*DATA_W +: DATA_W] = writeData[k*DATA_W +: DATA_W];
                        end else begin
                            readVal_s[i*DATA_W +: DATA_W] = readVal_s[i*DATA_W +: DATA_W];
                        end
                    end
                end else begin
                    readVal_s[i*DATA_W +: DATA_W] = readVal_s[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Registered read ports; hold when en is low, load zero while clearing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readData <= {(N_READ*DATA_W){1'b0}};
        end else if (en) begin
            if (state_r == CLEAR) begin
                readData <= {(N_READ*DATA_W){1'b0}};
            end else begin
                readData <= readVal_s;
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_phys_reg_file_mp
//
// Two instances share one stimulus stream:
//   dut0 : default geometry, BYPASS=1, ZERO_REG=0
//   dut1 : DEPTH=48 (addresses 48..63 out of range), BYPASS=0, ZERO_REG=1
// A reference model (plain arrays, whole-array clear on reset, a clear
// countdown) predicts readData/ready for the edge following each stimulus
// cycle. Predictions go into a per-instance queue; a monitor pops and compares
// just after every rising edge.
// -----------------------------------------------------------------------------
module tb_phys_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 12;
    localparam int NW = 4;

    logic              clk;
    logic              rstN;
    logic              en;
    logic              commitAllow;
    logic [NW-1:0]     commitVec;
    logic [NR*AW-1:0]  readSelect;
    logic [NW*AW-1:0]  writeSelect;
    logic [NW*DW-1:0]  writeData;
    logic [NR*DW-1:0]  rd0;
    logic [NR*DW-1:0]  rd1;
    logic              rdy0;
    logic              rdy1;

    phys_reg_file_mp dut0 (
        .clk(clk), .reset(rstN), .en(en), .commitAllow(commitAllow),
        .commitVec(commitVec), .readSelect(readSelect), .writeSelect(writeSelect),
        .writeData(writeData), .readData(rd0), .ready(rdy0)
    );

    phys_reg_file_mp #(.DEPTH(48), .BYPASS(0), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset(rstN), .en(en), .commitAllow(commitAllow),
        .commitVec(commitVec), .readSelect(readSelect), .writeSelect(writeSelect),
        .writeData(writeData), .readData(rd1), .ready(rdy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [NR*DW-1:0] rd;
        logic             rdy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   nCmp;
    int   nBad;

    // Reference model state, one slot per instance.
    int               mDepth [2];
    bit               mByp   [2];
    bit               mZero  [2];
    logic [DW-1:0]    mem    [2][64];
    logic [NR*DW-1:0] expRd  [2];
    logic             expRdy [2];
    int               clrCnt [2];

    task automatic chk(input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] req);
        nCmp++;
        if (act !== req) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic void modelAsyncReset(input int m);
        expRd[m]  = '0;
        expRdy[m] = 1'b0;
        clrCnt[m] = 0;
        for (int x = 0; x < 64; x++) mem[m][x] = '0;
    endfunction

    // Predict the effect of the coming rising edge for instance m.
    function automatic void modelStep(input int m);
        int            a;
        int            wa;
        bit            higher;
        logic [DW-1:0] v;
        if (!rstN) begin
            modelAsyncReset(m);
            return;
        end
        if (clrCnt[m] < mDepth[m]) begin
            if (en) expRd[m] = '0;
            clrCnt[m] = clrCnt[m] + 1;
            expRdy[m] = (clrCnt[m] == mDepth[m]);
            return;
        end
        if (en) begin
            for (int i = 0; i < NR; i++) begin
                a = int'(readSelect[i*AW +: AW]);
                if (a >= mDepth[m] || (mZero[m] && a == 0)) begin
                    v = '0;
                end else begin
                    v = mem[m][a];
                    if (mByp[m] && commitAllow) begin
                        for (int k = NW-1; k >= 0; k--) begin
                            if (commitVec[k] && int'(writeSelect[k*AW +: AW]) == a) begin
                                v = writeData[k*DW +: DW];
                                break;
                            end
                        end
                    end
                end
                expRd[m][i*DW +: DW] = v;
            end
        end
        if (commitAllow) begin
            for (int k = 0; k < NW; k++) begin
                wa = int'(writeSelect[k*AW +: AW]);
                if (commitVec[k] && wa < mDepth[m] && !(mZero[m] && wa == 0)) begin
                    higher = 1'b0;
                    for (int j = k + 1; j < NW; j++) begin
                        if (commitVec[j] && int'(writeSelect[j*AW +: AW]) == wa) higher = 1'b1;
                    end
                    if (!higher) mem[m][wa] = writeData[k*DW +: DW];
                end
            end
        end
    endfunction

    // Apply one cycle of stimulus at the falling edge and queue predictions.
    task automatic drive(input bit r, input bit e, input bit ca, input logic [NW-1:0] cv,
                         input logic [NR*AW-1:0] rs, input logic [NW*AW-1:0] ws,
                         input logic [NW*DW-1:0] wd);
        exp_t t;
        @(negedge clk);
        rstN        = r;
        en          = e;
        commitAllow = ca;
        commitVec   = cv;
        readSelect  = rs;
        writeSelect = ws;
        writeData   = wd;
        modelStep(0);
        modelStep(1);
        t.rd = expRd[0]; t.rdy = expRdy[0]; q0.push_back(t);
        t.rd = expRd[1]; t.rdy = expRdy[1]; q1.push_back(t);
    endtask

    function automatic logic [AW-1:0] randAddr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 63));
        else return AW'($urandom_range(0, 7));
    endfunction

    function automatic logic [NR*AW-1:0] randReads();
        logic [NR*AW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*AW +: AW] = randAddr();
        return r;
    endfunction

    function automatic logic [NW*AW-1:0] randWrites();
        logic [NW*AW-1:0] w;
        for (int k = 0; k < NW; k++) w[k*AW +: AW] = randAddr();
        return w;
    endfunction

    function automatic logic [NW*DW-1:0] randData();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic randCycle(input bit r);
        drive(r, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, NW'($urandom),
              randReads(), randWrites(), randData());
    endtask

    // Monitor: compare both instances just after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("dut0.readData", rd0, e.rd);
                chk("dut0.ready", (NR*DW)'(rdy0), (NR*DW)'(e.rdy));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("dut1.readData", rd1, e.rd);
                chk("dut1.ready", (NR*DW)'(rdy1), (NR*DW)'(e.rdy));
            end
        end
    end

    initial begin
        logic [NR*AW-1:0] rsP10;
        logic [NR*AW-1:0] rsP7;
        logic [NR*AW-1:0] rsP20;
        logic [NR*AW-1:0] rsP5;
        logic [NR*AW-1:0] rsP0;
        nCmp = 0;
        nBad = 0;
        mDepth[0] = 64; mByp[0] = 1'b1; mZero[0] = 1'b0;
        mDepth[1] = 48; mByp[1] = 1'b0; mZero[1] = 1'b1;
        modelAsyncReset(0);
        modelAsyncReset(1);
        rstN = 1'b0; en = 1'b1; commitAllow = 1'b0; commitVec = '0;
        readSelect = '0; writeSelect = '0; writeData = '0;
        rsP10 = {NR{6'd10}};
        rsP7  = {NR{6'd7}};
        rsP20 = {NR{6'd20}};
        rsP5  = {NR{6'd5}};
        rsP0  = {NR{6'd0}};

        // Reset held low for three cycles, commits to p5 attempted throughout.
        repeat (3) drive(1'b0, 1'b1, 1'b1, 4'b0001, randReads(), {NW{6'd5}}, {NW{32'h0000DEAD}});
        // Clear sequence: keep trying to commit p5 = 0xDEAD on every edge.
        repeat (64) drive(1'b1, 1'b1, 1'b1, 4'b0001, randReads(), {NW{6'd5}}, {NW{32'h0000DEAD}});
        drive(1'b1, 1'b1, 1'b0, 4'b0000, rsP5, '0, '0);

        // Basic write then read on every port (covers ports 0 and 11).
        drive(1'b1, 1'b1, 1'b1, 4'b0001, randReads(), {18'd0, 6'd10}, {96'd0, 32'h12345678});
        drive(1'b1, 1'b1, 1'b0, 4'b0000, rsP10, '0, '0);

        // Four ports hit p7 together; port 3 must win.
        drive(1'b1, 1'b1, 1'b1, 4'b1111, randReads(), {NW{6'd7}},
              {32'h00000003, 32'h00000002, 32'h00000001, 32'h00000000});
        drive(1'b1, 1'b1, 1'b0, 4'b0000, rsP7, '0, '0);

        // Same-cycle write and read of p20, then a plain read.
        drive(1'b1, 1'b1, 1'b1, 4'b0001, rsP20, {18'd0, 6'd20}, {96'd0, 32'h000000AA});
        drive(1'b1, 1'b1, 1'b0, 4'b0000, rsP20, '0, '0);

        // en low: readData must hold while selects move.
        drive(1'b1, 1'b1, 1'b0, 4'b0000, rsP10, '0, '0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 4'b0000, randReads(), '0, '0);

        // commitAllow low with every commitVec bit set: nothing may change.
        drive(1'b1, 1'b1, 1'b0, 4'b1111, rsP7, {NW{6'd10}}, randData());
        drive(1'b1, 1'b1, 1'b0, 4'b1111, rsP10, {NW{6'd7}}, randData());
        drive(1'b1, 1'b1, 1'b0, 4'b0000, rsP7, '0, '0);

        // Write p0 then read it (zero register on dut1 only).
        drive(1'b1, 1'b1, 1'b1, 4'b0001, randReads(), {18'd0, 6'd0}, {96'd0, 32'h000000FF});
        drive(1'b1, 1'b1, 1'b0, 4'b0000, rsP0, '0, '0);

        // Randomised traffic.
        repeat (300) randCycle(1'b1);

        // Reset mid-burst, asserted between edges: outputs must clear at once.
        @(posedge clk);
        #3;
        rstN = 1'b0;
        modelAsyncReset(0);
        modelAsyncReset(1);
        #1;
        chk("dut0.async_readData", rd0, '0);
        chk("dut0.async_ready", (NR*DW)'(rdy0), '0);
        chk("dut1.async_readData", rd1, '0);
        chk("dut1.async_ready", (NR*DW)'(rdy1), '0);
        repeat (2) randCycle(1'b0);
        repeat (70) randCycle(1'b1);
        repeat (100) randCycle(1'b1);

        repeat (2) @(posedge clk);
        #2;
        chk("queues_drained", (NR*DW)'(q0.size() + q1.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
